mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, giving the number of NTT core memory ports arbitrated (2..8).
REQ-002 The block SHALL have parameter RD_TIMEOUT, default 64, giving the cycles allowed for read data before error.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; asynchronous assertion, active-low, synchronous-free deassertion to clk.
REQ-005 core_req  in  NUM_CORES  per-core request, held high until its grant.
REQ-006 core_we  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
REQ-007 core_addr  in  64*NUM_CORES  per-core address, core i at bits [64i+63:64i].
REQ-008 core_wdata  in  64*NUM_CORES  per-core write data, same packing.
REQ-009 core_gnt  out  NUM_CORES  one-cycle grant pulse to the accepted core.
REQ-010 core_valid  out  NUM_CORES  one-cycle read-data-valid pulse to the owning core.
REQ-011 core_rdata  out  64  read data, broadcast to all cores, meaningful only with core_valid.
REQ-012 m_req, m_we  out  1 each  downstream memory request and write enable.
REQ-013 m_addr, m_wdata  out  64 each  downstream address and write data.
REQ-014 m_ready  in  1  memory accepts the request on a cycle where m_req && m_ready.
REQ-015 m_rvalid, m_rdata  in  1, 64  memory read return.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 rd_err  out  1  sticky read-timeout flag.

Function
REQ-018 States SHALL be IDLE, ISSUE, GNT, RD_WAIT; one transaction outstanding at a time.
REQ-019 IDLE: if any core_req bit set, select winner round-robin starting at pointer rr_ptr, latch its id, we, addr, wdata, go ISSUE; else stay.
REQ-020 Round-robin: search order rr_ptr, rr_ptr+1, ... wrapping modulo NUM_CORES; after selecting core k, rr_ptr SHALL become (k+1) mod NUM_CORES.
REQ-021 ISSUE: m_req=1 with latched we/addr/wdata held stable; on edge with m_ready=1 go GNT and drop m_req.
REQ-022 GNT: core_gnt[id]=1 for exactly this one cycle; core_req is not sampled in GNT; next state RD_WAIT if read, else IDLE.
REQ-023 RD_WAIT: on m_rvalid, register m_rdata into core_rdata and pulse core_valid[id] next cycle, go IDLE.
REQ-024 RD_WAIT timeout: counter starts at 0 on entry; if it reaches RD_TIMEOUT without m_rvalid, set rd_err, pulse core_valid[id] with core_rdata=0, go IDLE.
REQ-025 m_rvalid outside RD_WAIT SHALL be ignored (no core_valid, no state change).
REQ-026 Write minimum latency: request seen in IDLE at cycle T -> m_req at T+1 -> core_gnt at T+2 when m_ready is already high.
REQ-027 Request deasserted while in ISSUE SHALL NOT abort the latched transaction.
REQ-028 At most one bit of core_gnt and of core_valid SHALL be high in any cycle.

Reset
REQ-029 On rst low, immediately: state IDLE, rr_ptr 0, m_req 0, m_we 0, m_addr 0, m_wdata 0, core_gnt 0, core_valid 0, core_rdata 0, busy 0, rd_err 0, timeout counter 0.
REQ-030 Reset mid-transaction SHALL discard it; no grant or valid pulse follows reset release.
REQ-031 rd_err SHALL clear only by reset.

Verification
REQ-032 Single write: core 1 req, we=1, addr 0x64+8, wdata 0xDEADBEEF, m_ready=1 -> m_addr=0x6C/m_wdata=0xDEADBEEF one cycle, core_gnt=0b0010 two cycles after req, back to IDLE.
REQ-033 Single read: core 0 read addr 0, memory returns 0x1234 via m_rvalid 3 cycles after accept -> core_valid=0b0001, core_rdata=0x1234 next cycle.
REQ-034 Contention: all 4 cores request writes simultaneously from reset -> grant order 0,1,2,3; re-request of core 0 after core 2 then orders 3,0.
REQ-035 Backpressure: m_ready low 5 cycles -> m_req and m_addr stable for 6 cycles, single core_gnt after acceptance.
REQ-036 Timeout: read accepted, m_rvalid never -> after 64 cycles rd_err=1, core_valid pulse with rdata 0; later stray m_rvalid ignored.
REQ-037 Reset in RD_WAIT: rst low mid-read -> all outputs zero at once, no core_valid after release, rr_ptr back to 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the NTT cores, the arbiter and the
// downstream memory.
//   core_req/core_we/core_addr/core_wdata : per-core request, packed 64 bits per core
//   core_gnt/core_valid/core_rdata        : per-core grant / read-valid pulses, shared read data
//   m_req/m_we/m_addr/m_wdata             : single downstream request
//   m_ready/m_rvalid/m_rdata              : downstream accept and read return
//   busy/rd_err                           : arbiter status
// The arbiter uses the slave modport; cores plus memory (or a bench) use master.
interface mem_arbiter_if #(
  parameter int NUM_CORES = 4
) ();
  logic [NUM_CORES-1:0]    core_req;
  logic [NUM_CORES-1:0]    core_we;
  logic [64*NUM_CORES-1:0] core_addr;
  logic [64*NUM_CORES-1:0] core_wdata;
  logic [NUM_CORES-1:0]    core_gnt;
  logic [NUM_CORES-1:0]    core_valid;
  logic [63:0]             core_rdata;
  logic                    m_req;
  logic                    m_we;
  logic [63:0]             m_addr;
  logic [63:0]             m_wdata;
  logic                    m_ready;
  logic                    m_rvalid;
  logic [63:0]             m_rdata;
  logic                    busy;
  logic                    rd_err;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_valid, core_rdata,
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata,
    output busy, rd_err
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_valid, core_rdata,
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata,
    input  busy, rd_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving NUM_CORES NTT cores access to one
// memory port, one transaction outstanding at a time.
//   clk    : single clock, all state changes on its rising edge
//   rst    : asynchronous, active-low reset
//   bus    : mem_arbiter_if slave modport (core side, memory side, status)
// Flow: IDLE picks a winner and latches its request, ISSUE holds m_req until
// m_ready, GNT pulses core_gnt, RD_WAIT waits for m_rvalid or times out.
module mem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int RD_TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_CORES);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    GNT     = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     id_q, id_d;
  logic                 we_q, we_d;
  logic [63:0]          addr_q, addr_d;
  logic [63:0]          wdata_q, wdata_d;
  logic                 m_req_q, m_req_d;
  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic [NUM_CORES-1:0] valid_q, valid_d;
  logic [63:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     cand;

  // Round-robin search: first requesting core starting at rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    cand   = rr_ptr_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_CORES);
      if (!found && bus.core_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    m_req_d  = m_req_q;
    gnt_d    = '0;
    valid_d  = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d     = winner;
          we_d     = bus.core_we[winner];
          addr_d   = bus.core_addr[int'(winner)*64 +: 64];
          wdata_d  = bus.core_wdata[int'(winner)*64 +: 64];
          rr_ptr_d = (int'(winner) == NUM_CORES - 1) ? '0 : winner + PTR_W'(1);
          m_req_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The latched request is issued even if the core drops core_req now.
        if (bus.m_ready) begin
          m_req_d     = 1'b0;
          gnt_d[id_q] = 1'b1;
          state_d     = GNT;
        end
      end
      GNT: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // cnt_q counts RD_WAIT cycles already spent without read data; the
        // timeout fires on the cycle that would bring it to RD_TIMEOUT.
        if (bus.m_rvalid) begin
          valid_d[id_q] = 1'b1;
          rdata_d       = bus.m_rdata;
          state_d       = IDLE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          valid_d[id_q] = 1'b1;
          rdata_d       = '0;
          err_d         = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      m_req_q  <= 1'b0;
      gnt_q    <= '0;
      valid_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      m_req_q  <= m_req_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.m_req      = m_req_q;
  assign bus.m_we       = we_q;
  assign bus.m_addr     = addr_q;
  assign bus.m_wdata    = wdata_q;
  assign bus.core_gnt   = gnt_q;
  assign bus.core_valid = valid_q;
  assign bus.core_rdata = rdata_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.rd_err     = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (4 cores, 64-cycle
// read timeout). Acts as the cores and as the downstream memory.
// Directed transactions come from a table; contention, timeout and reset
// sequences are hand-written; a random phase compares against a
// transaction-level model (round-robin pick from the pending set plus a
// memory array).
module tb_mem_arbiter;
  localparam int N   = 4;
  localparam int RDT = 64;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.NUM_CORES(N)) bus ();

  mem_arbiter #(.NUM_CORES(N), .RD_TIMEOUT(RDT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int model_ptr    = 0;

  typedef struct {
    int          core;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          ready_delay;
    int          rvalid_delay;
    logic [63:0] rdata;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_valid;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef enum {AWAIT_REQ, ON_BUS, ACKED, AWAIT_DATA} stage_t;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_core(input int c, input bit req, input bit we, input logic [63:0] a, input logic [63:0] d);
    bus.core_req[c]            = req;
    bus.core_we[c]             = we;
    bus.core_addr[64*c +: 64]  = a;
    bus.core_wdata[64*c +: 64] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_m_req"}, bus.m_req, 0);
    check_output({tag, "_m_we"}, bus.m_we, 0);
    check_output({tag, "_m_addr"}, bus.m_addr, 0);
    check_output({tag, "_m_wdata"}, bus.m_wdata, 0);
    check_output({tag, "_gnt"}, bus.core_gnt, 0);
    check_output({tag, "_valid"}, bus.core_valid, 0);
    check_output({tag, "_rdata"}, bus.core_rdata, 0);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_rd_err"}, bus.rd_err, 0);
  endtask

  function automatic int rr_pick(input bit [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++)
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // One complete isolated transaction from the vector table.
  task automatic apply_stimulus(input vec_t v);
    set_core(v.core, 1'b1, v.we, v.addr, v.wdata);
    bus.m_ready = (v.ready_delay == 0);
    for (int k = 0; k <= v.ready_delay; k++) begin
      @(negedge clk);
      check_output("issue_m_req", bus.m_req, 1);
      check_output("issue_m_we", bus.m_we, v.we);
      check_output("issue_m_addr", bus.m_addr, v.addr);
      check_output("issue_m_wdata", bus.m_wdata, v.wdata);
      check_output("issue_no_gnt", bus.core_gnt, 0);
      bus.m_ready = (k == v.ready_delay);
    end
    @(negedge clk);
    check_output("vec_gnt", bus.core_gnt, v.exp_gnt);
    check_output("vec_gnt_m_req", bus.m_req, 0);
    bus.core_req[v.core] = 1'b0;
    bus.m_ready          = 1'b0;
    model_ptr            = (v.core + 1) % N;
    if (!v.we) begin
      for (int k = 0; k <= v.rvalid_delay; k++) begin
        @(negedge clk);
        check_output("rdwait_valid", bus.core_valid, 0);
        check_output("rdwait_busy", bus.busy, 1);
      end
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = v.rdata;
    end
    @(negedge clk);
    bus.m_rvalid = 1'b0;
    check_output("vec_valid", bus.core_valid, v.exp_valid);
    if (!v.we) check_output("vec_rdata", bus.core_rdata, v.exp_rdata);
    check_output("vec_idle", bus.busy, 0);
    check_output("vec_rd_err", bus.rd_err, 0);
  endtask

  vec_t vecs [6];
  logic [63:0] mem [16];
  bit   [N-1:0] act;
  bit           cwe   [N];
  logic [63:0]  caddr [N];
  logic [63:0]  cwdata[N];
  int           cidx  [N];

  task automatic random_starts(input int blocked);
    for (int c = 0; c < N; c++) begin
      if (!act[c] && c != blocked && $urandom_range(0, 3) == 0) begin
        cwe[c]    = 1'($urandom_range(0, 1));
        cidx[c]   = $urandom_range(0, 15);
        caddr[c]  = 64'h1000 + 64'(cidx[c]) * 8;
        cwdata[c] = {$urandom, $urandom};
        act[c]    = 1'b1;
        set_core(c, 1'b1, cwe[c], caddr[c], cwdata[c]);
      end
    end
  endtask

  initial begin
    int gq[$];
    int exp_order[5];
    stage_t stage;
    int cur_id, wait_left, val_id;
    bit val_due, done, stop_new;
    logic [63:0] exp_rd;

    vecs[0] = '{1, 1'b1, 64'h6C,        64'hDEADBEEF,          0, 0, 64'h0,                 4'b0010, 4'b0000, 64'h0};
    vecs[1] = '{0, 1'b0, 64'h0,         64'h0,                 0, 1, 64'h1234,              4'b0001, 4'b0001, 64'h1234};
    vecs[2] = '{2, 1'b1, 64'h100,       64'h0123456789ABCDEF,  5, 0, 64'h0,                 4'b0100, 4'b0000, 64'h0};
    vecs[3] = '{3, 1'b0, 64'h2222_0008, 64'h0,                 2, 0, 64'hA5A5_5A5A_F00D_BEEF, 4'b1000, 4'b1000, 64'hA5A5_5A5A_F00D_BEEF};
    vecs[4] = '{2, 1'b0, 64'hFFFF_FFF8, 64'h0,                 0, 4, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{3, 1'b1, 64'h40,        64'h1,                 1, 0, 64'h0,                 4'b1000, 4'b0000, 64'h0};
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 16; i++) mem[i] = '0;

    bus.core_req = '0; bus.core_we = '0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    rst = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b1;

    // Contention from reset: all four write at once, core 0 re-requests after core 2.
    for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b1, 64'h100 * c, 64'h5000 + c);
    bus.m_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && gq.size() < 5; cyc++) begin
      @(negedge clk);
      check_output("contention_onehot", 64'($countones(bus.core_gnt) > 1), 0);
      for (int c = 0; c < N; c++) begin
        if (bus.core_gnt[c]) begin
          gq.push_back(c);
          bus.core_req[c] = 1'b0;
          if (c == 2) bus.core_req[0] = 1'b1;
        end
      end
    end
    check_output("contention_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check_output("contention_order", gq[i], exp_order[i]);
    bus.core_req = '0; bus.m_ready = 1'b0;
    model_ptr = 1;
    @(negedge clk);
    check_output("contention_idle", bus.busy, 0);

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Random traffic against the transaction-level model.
    act = '0; stage = AWAIT_REQ; val_due = 0; done = 0; stop_new = 0;
    cur_id = 0; wait_left = 0; val_id = 0; exp_rd = '0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk);
      stop_new = (cyc >= 3000);
      check_output("rnd_gnt_onehot", 64'($countones(bus.core_gnt) > 1), 0);
      check_output("rnd_rd_err", bus.rd_err, 0);
      if (val_due) begin
        check_output("rnd_valid", bus.core_valid, 64'(1) << val_id);
        check_output("rnd_rdata", bus.core_rdata, exp_rd);
        val_due = 0;
      end else begin
        check_output("rnd_no_valid", bus.core_valid, 0);
      end
      case (stage)
        AWAIT_REQ: begin
          check_output("rnd_idle_m_req", bus.m_req, 0);
          check_output("rnd_idle_gnt", bus.core_gnt, 0);
          check_output("rnd_idle_busy", bus.busy, 0);
        end
        ON_BUS: begin
          check_output("rnd_m_req", bus.m_req, 1);
          check_output("rnd_m_we", bus.m_we, cwe[cur_id]);
          check_output("rnd_m_addr", bus.m_addr, caddr[cur_id]);
          check_output("rnd_m_wdata", bus.m_wdata, cwdata[cur_id]);
          check_output("rnd_bus_gnt", bus.core_gnt, 0);
        end
        ACKED: begin
          check_output("rnd_gnt", bus.core_gnt, 64'(1) << cur_id);
          check_output("rnd_gnt_m_req", bus.m_req, 0);
        end
        default: begin
          check_output("rnd_wait_gnt", bus.core_gnt, 0);
          check_output("rnd_wait_busy", bus.busy, 1);
        end
      endcase

      bus.m_rvalid = 1'b0;
      bus.m_rdata  = {$urandom, $urandom};
      bus.m_ready  = 1'($urandom_range(0, 1));
      case (stage)
        AWAIT_REQ: begin
          if (!stop_new) random_starts(-1);
          if (act != 0) begin
            cur_id    = rr_pick(act, model_ptr);
            model_ptr = (cur_id + 1) % N;
            stage     = ON_BUS;
          end else if (stop_new) begin
            done = 1;
          end
          bus.m_rvalid = 1'($urandom_range(0, 1));
        end
        ON_BUS: begin
          if ($urandom_range(0, 7) == 0) begin
            act[cur_id] = 1'b0;
            bus.core_req[cur_id] = 1'b0;
          end
          if (!stop_new) random_starts(cur_id);
          bus.m_rvalid = 1'($urandom_range(0, 1));
          if (bus.m_ready) begin
            if (cwe[cur_id]) mem[cidx[cur_id]] = cwdata[cur_id];
            stage = ACKED;
          end
        end
        ACKED: begin
          act[cur_id] = 1'b0;
          bus.core_req[cur_id] = 1'b0;
          if (!stop_new) random_starts(cur_id);
          bus.m_rvalid = 1'($urandom_range(0, 1));
          wait_left = $urandom_range(0, 6);
          stage = cwe[cur_id] ? AWAIT_REQ : AWAIT_DATA;
        end
        default: begin
          if (!stop_new) random_starts(-1);
          if (wait_left == 0) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = mem[cidx[cur_id]];
            exp_rd  = mem[cidx[cur_id]];
            val_id  = cur_id;
            val_due = 1;
            stage   = AWAIT_REQ;
          end else begin
            wait_left--;
          end
        end
      endcase
    end
    check_output("random_drained", 64'(done), 1);
    bus.core_req = '0; bus.m_ready = 1'b0; bus.m_rvalid = 1'b0;
    @(negedge clk);

    // Read timeout, then stray m_rvalid while idle.
    set_core(1, 1'b1, 1'b0, 64'h3000, 64'h0);
    bus.m_ready = 1'b1;
    @(negedge clk);
    check_output("to_issue", bus.m_req, 1);
    @(negedge clk);
    check_output("to_gnt", bus.core_gnt, 4'b0010);
    bus.core_req[1] = 1'b0; bus.m_ready = 1'b0;
    for (int k = 1; k <= RDT; k++) begin
      @(negedge clk);
      check_output("to_wait_valid", bus.core_valid, 0);
      check_output("to_wait_err", bus.rd_err, 0);
    end
    @(negedge clk);
    check_output("to_valid", bus.core_valid, 4'b0010);
    check_output("to_rdata", bus.core_rdata, 0);
    check_output("to_err", bus.rd_err, 1);
    check_output("to_idle", bus.busy, 0);
    bus.m_rvalid = 1'b1; bus.m_rdata = 64'hBAD0_BAD0;
    repeat (3) begin
      @(negedge clk);
      check_output("stray_valid", bus.core_valid, 0);
      check_output("stray_busy", bus.busy, 0);
      check_output("stray_err_sticky", bus.rd_err, 1);
    end
    bus.m_rvalid = 1'b0;

    // Reset while waiting for read data.
    set_core(2, 1'b1, 1'b0, 64'h2000_0010, 64'h0);
    bus.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_seq_gnt", bus.core_gnt, 4'b0100);
    bus.core_req[2] = 1'b0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_seq_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    bus.m_rvalid = 1'b1; bus.m_rdata = 64'h7777;
    @(negedge clk);
    bus.m_rvalid = 1'b0;
    repeat (4) begin
      check_output("post_rst_valid", bus.core_valid, 0);
      check_output("post_rst_gnt", bus.core_gnt, 0);
      check_output("post_rst_busy", bus.busy, 0);
      @(negedge clk);
    end
    set_core(3, 1'b1, 1'b1, 64'h30, 64'h3);
    set_core(1, 1'b1, 1'b1, 64'h10, 64'h1);
    bus.m_ready = 1'b1;
    @(negedge clk);
    check_output("post_rst_m_addr", bus.m_addr, 64'h10);
    @(negedge clk);
    check_output("post_rst_ptr_gnt", bus.core_gnt, 4'b0010);
    bus.core_req = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
